// File: rtl/ioctl_upload_packer.sv
// ---------------------------------------------------------------------------
// ioctl_upload_packer
//
// Reads a block of bytes from the core one at a time over the ioctl read
// port. It packs them MSB-first into 32-bit words and hands each word to
// the host with a req/ack handshake. An upload is requested by a one-cycle
// start pulse that carries the byte count and the menu/file index.
//
// Ports
//   clk_sys            sole clock, rising edge
//   reset              synchronous, active-high
//   host_upload_start  one-cycle upload request (ignored unless idle)
//   host_upload_size   byte count, sampled with start
//   host_upload_index  menu/file index, sampled with start
//   host_updata        packed word to the host (lane 0 in [31:24])
//   host_updata_req    word valid, held until host_updata_ack
//   host_updata_ack    one-cycle acknowledge, only honoured while sending
//   host_upload_busy   upload in progress
//   host_upload_done   one-cycle completion pulse
//   ioctl_upload       core-side upload active (same as busy)
//   ioctl_index        latched index, held until the next accepted start
//   ioctl_addr         byte address being read
//   ioctl_rd           one-cycle read strobe
//   ioctl_din          byte returned by the core
//   ioctl_wait         core stall; ioctl_din not valid while high
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for host_upload_start
// READ  | ioctl_rd strobe for the current ioctl_addr
// WAITD | waiting for ioctl_wait low, then capture ioctl_din into a lane
// SEND  | host_updata_req high until host_updata_ack
// FIN   | host_upload_done pulse, busy/upload already low
// ---------------------------------------------------------------------------
module ioctl_upload_packer #(
    parameter int SIZE_W = 16,
    parameter int ADDR_W = 27
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              host_upload_start,
    input  logic [SIZE_W-1:0] host_upload_size,
    input  logic [15:0]       host_upload_index,
    output logic [31:0]       host_updata,
    output logic              host_updata_req,
    input  logic              host_updata_ack,
    output logic              host_upload_busy,
    output logic              host_upload_done,
    output logic              ioctl_upload,
    output logic [15:0]       ioctl_index,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic              ioctl_rd,
    input  logic [7:0]        ioctl_din,
    input  logic              ioctl_wait
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAITD = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] byte_cnt;
    logic [SIZE_W-1:0] byte_cnt_inc;
    logic [1:0]        lane;
    logic [31:0]       word_q;

    logic              start_ok;
    logic              capture;
    logic              last_byte;
    logic              word_full;
    logic              all_sent;
    logic              word_acked;

    // A start is only honoured from IDLE; while busy it is dropped and the
    // latched size/index stay untouched.
    assign start_ok     = (state == ST_IDLE) && host_upload_start;

    // WAITD is always entered one cycle after READ, so a capture can never
    // coincide with the read strobe.
    assign capture      = (state == ST_WAITD) && !ioctl_wait;

    // byte_cnt < size_q while reading, so the increment never overflows.
    assign byte_cnt_inc = byte_cnt + SIZE_W'(1);
    assign last_byte    = (byte_cnt_inc == size_q);
    assign word_full    = (lane == 2'd3);
    assign all_sent     = (byte_cnt == size_q);
    assign word_acked   = (state == ST_SEND) && host_updata_ack;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (host_upload_start) begin
                    state_nxt = (host_upload_size == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_WAITD;
            end
            ST_WAITD: begin
                if (!ioctl_wait) begin
                    state_nxt = (word_full || last_byte) ? ST_SEND : ST_READ;
                end
            end
            ST_SEND: begin
                if (host_updata_ack) begin
                    state_nxt = all_sent ? ST_FIN : ST_READ;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ioctl_rd         = 1'b0;
        host_updata_req  = 1'b0;
        host_upload_busy = 1'b0;
        host_upload_done = 1'b0;
        ioctl_upload     = 1'b0;
        case (state)
            ST_READ: begin
                ioctl_rd         = 1'b1;
                host_upload_busy = 1'b1;
                ioctl_upload     = 1'b1;
            end
            ST_WAITD: begin
                host_upload_busy = 1'b1;
                ioctl_upload     = 1'b1;
            end
            ST_SEND: begin
                host_updata_req  = 1'b1;
                host_upload_busy = 1'b1;
                ioctl_upload     = 1'b1;
            end
            ST_FIN: begin
                // busy and upload drop in the same cycle as the done pulse
                host_upload_done = 1'b1;
            end
            default: begin
                ioctl_rd = 1'b0;
            end
        endcase
    end

    assign host_updata = word_q;

    // -----------------------------------------------------------------------
    // Datapath: latched request, address/byte/lane counters, word assembly
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            size_q      <= '0;
            byte_cnt    <= '0;
            lane        <= '0;
            word_q      <= '0;
            ioctl_index <= '0;
            ioctl_addr  <= '0;
        end else if (start_ok) begin
            size_q      <= host_upload_size;
            ioctl_index <= host_upload_index;
            byte_cnt    <= '0;
            lane        <= '0;
            word_q      <= '0;
            ioctl_addr  <= '0;
        end else if (capture) begin
            case (lane)
                2'd0:    word_q[31:24] <= ioctl_din;
                2'd1:    word_q[23:16] <= ioctl_din;
                2'd2:    word_q[15:8]  <= ioctl_din;
                default: word_q[7:0]   <= ioctl_din;
            endcase
            ioctl_addr <= ioctl_addr + ADDR_W'(1);
            byte_cnt   <= byte_cnt_inc;
            lane       <= lane + 2'd1;
        end else if (word_acked && !all_sent) begin
            // Clearing the word here keeps the unused lanes of a final
            // partial word at zero.
            word_q <= '0;
            lane   <= '0;
        end
    end

endmodule

// File: tb/tb_ioctl_upload_packer.sv
// ---------------------------------------------------------------------------
// tb_ioctl_upload_packer
//
// Self-checking bench for ioctl_upload_packer. It models the core as a byte
// array with optional stall cycles and the host as an acknowledger with an
// optional delay. Every word received is compared with the byte array
// packed MSB-first and zero-padded.
// ---------------------------------------------------------------------------
module tb_ioctl_upload_packer;

    logic        clk_sys;
    logic        reset;
    logic        host_upload_start;
    logic [15:0] host_upload_size;
    logic [15:0] host_upload_index;
    logic [31:0] host_updata;
    logic        host_updata_req;
    logic        host_updata_ack;
    logic        host_upload_busy;
    logic        host_upload_done;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    logic [7:0]  mem [0:255];

    int n_cmp;
    int n_fail;

    ioctl_upload_packer dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .host_upload_start (host_upload_start),
        .host_upload_size  (host_upload_size),
        .host_upload_index (host_upload_index),
        .host_updata       (host_updata),
        .host_updata_req   (host_updata_req),
        .host_updata_ack   (host_updata_ack),
        .host_upload_busy  (host_upload_busy),
        .host_upload_done  (host_upload_done),
        .ioctl_upload      (ioctl_upload),
        .ioctl_index       (ioctl_index),
        .ioctl_addr        (ioctl_addr),
        .ioctl_rd          (ioctl_rd),
        .ioctl_din         (ioctl_din),
        .ioctl_wait        (ioctl_wait)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference packing: n bytes of mem from base, first byte in [31:24],
    // missing lanes zero.
    function automatic logic [31:0] pack(input int base, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < n; k++) begin
            w[31-8*k -: 8] = mem[base+k];
        end
        return w;
    endfunction

    task automatic fill_mem(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(int'(base) + int'(step) * i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_updata"}, host_updata, 32'h0);
        check({tag, "_req"},    32'(host_updata_req), 32'h0);
        check({tag, "_busy"},   32'(host_upload_busy), 32'h0);
        check({tag, "_done"},   32'(host_upload_done), 32'h0);
        check({tag, "_upload"}, 32'(ioctl_upload), 32'h0);
        check({tag, "_index"},  32'(ioctl_index), 32'h0);
        check({tag, "_addr"},   32'(ioctl_addr), 32'h0);
        check({tag, "_rd"},     32'(ioctl_rd), 32'h0);
    endtask

    // One complete upload. The bench acts as core and host on every falling
    // edge, checks protocol details cycle by cycle, then compares the
    // collected words with the reference packing of mem.
    task automatic run_transfer(
        input  int          size,
        input  logic [15:0] idx,
        input  int          stall_read,
        input  int          stall_len,
        input  int          ack_delay,
        input  bit          second_start,
        input  bit          rnd,
        output int          n_words,
        output logic [31:0] w0,
        output logic [31:0] wl
    );
        logic [31:0] words[$];
        logic [31:0] held;
        int  rd_cnt, cyc, done_cyc, stall_left, ack_left, exp_nwords, nb;
        bit  pend, in_send, ack_sent, finished;

        rd_cnt = 0; cyc = 1; done_cyc = 0; stall_left = 0; ack_left = 0;
        pend = 0; in_send = 0; ack_sent = 0; finished = 0; held = 32'h0;

        @(negedge clk_sys);
        host_upload_start = 1'b1;
        host_upload_size  = 16'(size);
        host_upload_index = idx;
        @(negedge clk_sys);
        host_upload_start = 1'b0;
        host_upload_size  = 16'hFFFF;
        host_upload_index = ~idx;

        while (!finished && cyc < 4000) begin
            host_updata_ack   = 1'b0;
            host_upload_start = 1'b0;
            if (ack_sent) begin
                check("req_drop_after_ack", 32'(host_updata_req), 32'h0);
                ack_sent = 0;
                in_send  = 0;
            end
            if (host_upload_done) begin
                finished = 1;
                done_cyc = cyc;
                check("busy_low_at_done", 32'(host_upload_busy), 32'h0);
                check("upload_low_at_done", 32'(ioctl_upload), 32'h0);
                check("final_addr", 32'(ioctl_addr), 32'(size));
                check("final_index", 32'(ioctl_index), 32'(idx));
            end else begin
                check("busy_during", 32'(host_upload_busy), 32'(size != 0));
                check("upload_during", 32'(ioctl_upload), 32'(size != 0));
                // core side
                if (ioctl_rd) begin
                    check("rd_addr", 32'(ioctl_addr), 32'(rd_cnt));
                    rd_cnt++;
                    pend       = 1;
                    stall_left = rnd ? int'($urandom_range(0, 3))
                                     : ((rd_cnt == stall_read) ? stall_len : 0);
                    ioctl_wait = 1'b1;
                    ioctl_din  = 8'hEE;
                end else if (pend) begin
                    if (stall_left > 0) begin
                        check("stall_addr", 32'(ioctl_addr), 32'(rd_cnt - 1));
                        check("stall_data", host_updata,
                              pack(((rd_cnt - 1) / 4) * 4, (rd_cnt - 1) % 4));
                        ioctl_wait = 1'b1;
                        ioctl_din  = 8'hEE;
                        stall_left--;
                    end else begin
                        ioctl_wait = 1'b0;
                        ioctl_din  = mem[ioctl_addr[7:0]];
                        pend       = 0;
                    end
                end else begin
                    ioctl_wait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    ioctl_din  = 8'($urandom);
                end
                // host side
                if (host_updata_req && !ack_sent) begin
                    if (!in_send) begin
                        in_send  = 1;
                        held     = host_updata;
                        ack_left = rnd ? int'($urandom_range(0, 4)) : ack_delay;
                        if (second_start && words.size() == 0) begin
                            host_upload_start = 1'b1;
                            host_upload_size  = 16'd3;
                            host_upload_index = idx ^ 16'hFFFF;
                        end
                    end else begin
                        check("data_stable", host_updata, held);
                    end
                    if (ack_left == 0) begin
                        host_updata_ack = 1'b1;
                        words.push_back(host_updata);
                        ack_sent = 1;
                    end else begin
                        ack_left--;
                    end
                end else if (rnd && !host_updata_req) begin
                    // stray acks outside SEND must be ignored
                    host_updata_ack = ($urandom_range(0, 3) == 0);
                end
            end
            if (!finished) begin
                @(negedge clk_sys);
                cyc++;
            end
        end

        host_updata_ack   = 1'b0;
        host_upload_start = 1'b0;
        ioctl_wait        = 1'b0;
        check("done_seen", 32'(finished), 32'h1);
        check("rd_count", 32'(rd_cnt), 32'(size));
        exp_nwords = (size + 3) / 4;
        check("word_count", 32'(words.size()), 32'(exp_nwords));
        for (int j = 0; j < words.size() && j < exp_nwords; j++) begin
            nb = (size - 4 * j < 4) ? size - 4 * j : 4;
            check("word_data", words[j], pack(4 * j, nb));
        end
        if (size == 0) begin
            check("size0_done_latency", 32'(done_cyc), 32'h1);
        end else if (!rnd && stall_read < 0 && ack_delay == 0) begin
            check("throughput", 32'(done_cyc <= 2 * size + 2 * exp_nwords + 1), 32'h1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            check("done_single_pulse", 32'(host_upload_done), 32'h0);
            check("idle_busy", 32'(host_upload_busy), 32'h0);
            check("idle_rd", 32'(ioctl_rd), 32'h0);
        end

        n_words = words.size();
        w0 = (words.size() > 0) ? words[0] : 32'h0;
        wl = (words.size() > 0) ? words[words.size() - 1] : 32'h0;
    endtask

    typedef struct {
        int          size;
        logic [15:0] idx;
        logic [7:0]  base;
        logic [7:0]  step;
        int          stall_read;
        int          stall_len;
        int          ack_delay;
        bit          second_start;
        int          exp_nwords;
        logic [31:0] exp_w0;
        logic [31:0] exp_wl;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          nw;
        logic [31:0] w0;
        logic [31:0] wl;
        bit          got;
        int          rsize;

        n_cmp = 0;
        n_fail = 0;

        vecs[0] = '{4, 16'h0001, 8'h11, 8'h11, -1, 0, 0,  1'b0, 1, 32'h11223344, 32'h11223344};
        vecs[1] = '{6, 16'h0102, 8'hA0, 8'h01, -1, 0, 0,  1'b0, 2, 32'hA0A1A2A3, 32'hA4A50000};
        vecs[2] = '{0, 16'h0203, 8'h00, 8'h00, -1, 0, 0,  1'b0, 0, 32'h00000000, 32'h00000000};
        vecs[3] = '{8, 16'h0304, 8'h30, 8'h03,  2, 5, 0,  1'b0, 2, 32'h30333639, 32'h3C3F4245};
        vecs[4] = '{5, 16'h0405, 8'hC0, 8'h0F, -1, 0, 10, 1'b1, 2, 32'hC0CFDEED, 32'hFC000000};
        vecs[5] = '{1, 16'hBEEF, 8'h5A, 8'h00, -1, 0, 0,  1'b0, 1, 32'h5A000000, 32'h5A000000};
        vecs[6] = '{7, 16'h0607, 8'h01, 8'h01, -1, 0, 0,  1'b0, 2, 32'h01020304, 32'h05060700};

        reset             = 1'b1;
        host_upload_start = 1'b0;
        host_upload_size  = 16'h0;
        host_upload_index = 16'h0;
        host_updata_ack   = 1'b0;
        ioctl_din         = 8'h0;
        ioctl_wait        = 1'b0;
        repeat (2) @(negedge clk_sys);
        check_reset_outputs("reset_state");
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill_mem(vecs[v].base, vecs[v].step);
            run_transfer(vecs[v].size, vecs[v].idx, vecs[v].stall_read, vecs[v].stall_len,
                         vecs[v].ack_delay, vecs[v].second_start, 1'b0, nw, w0, wl);
            check("vec_nwords", 32'(nw), 32'(vecs[v].exp_nwords));
            check("vec_first_word", w0, vecs[v].exp_w0);
            check("vec_last_word", wl, vecs[v].exp_wl);
        end

        // Reset while a size-8 transfer sits in SEND, together with start,
        // ack and wait in the same cycle.
        fill_mem(8'h70, 8'h01);
        @(negedge clk_sys);
        host_upload_start = 1'b1;
        host_upload_size  = 16'd8;
        host_upload_index = 16'h0042;
        @(negedge clk_sys);
        host_upload_start = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            ioctl_wait = 1'b0;
            ioctl_din  = mem[ioctl_addr[7:0]];
            if (host_updata_req) got = 1;
            else @(negedge clk_sys);
        end
        check("reach_send", 32'(host_updata_req), 32'h1);
        check("send_word_before_reset", host_updata, 32'h70717273);
        reset             = 1'b1;
        host_upload_start = 1'b1;
        host_upload_size  = 16'd9;
        host_upload_index = 16'h7777;
        host_updata_ack   = 1'b1;
        ioctl_wait        = 1'b1;
        @(negedge clk_sys);
        check_reset_outputs("mid_reset");
        reset             = 1'b0;
        host_upload_start = 1'b0;
        host_updata_ack   = 1'b0;
        ioctl_wait        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            check("post_reset_no_done", 32'(host_upload_done), 32'h0);
            check("post_reset_idle", 32'(host_upload_busy), 32'h0);
        end
        fill_mem(8'h90, 8'h02);
        run_transfer(4, 16'h0055, -1, 0, 0, 1'b0, 1'b0, nw, w0, wl);
        check("post_reset_word", w0, 32'h90929496);

        // Randomised transfers against the reference packing.
        for (int r = 0; r < 12; r++) begin
            rsize = int'($urandom_range(0, 40));
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run_transfer(rsize, 16'($urandom), -1, 0, 0, 1'b0, 1'b1, nw, w0, wl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
